// File: rtl/step_commit_unit.sv
// Step commit unit: applies the adaptive step verdict by advancing time, copying
// the candidate state vector over the current one, and clamping the next step to t_end.
//
//   state | meaning
//   IDLE  | waiting for a step verdict
//   COPY  | pipelined x1 -> x0 copy, one word per cycle plus one drain cycle
//   CLAMP | commit complete; next step limited to the remaining time
//   HALT  | finished or failed; only init or rst leaves
module step_commit_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic [WORD_SIZE-1:0]     t0_in,
  input  logic [WORD_SIZE-1:0]     t_end_in,
  input  logic [WORD_SIZE-1:0]     h0_in,
  input  logic [WORD_SIZE-1:0]     n_in,
  input  logic [ADDRESS_WIDTH-1:0] x0_address,
  input  logic [ADDRESS_WIDTH-1:0] x1_address,
  input  logic                     start,
  input  logic                     proceed,
  input  logic                     error_failure,
  input  logic [WORD_SIZE-1:0]     step_in,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  input  logic [WORD_SIZE-1:0]     mem_rd_data,
  output logic [ADDRESS_WIDTH-1:0] mem_wr_addr,
  output logic [WORD_SIZE-1:0]     mem_wr_data,
  output logic                     mem_wr_en,
  output logic [WORD_SIZE-1:0]     t_out,
  output logic [WORD_SIZE-1:0]     h_out,
  output logic                     busy,
  output logic                     accepted,
  output logic                     rejected,
  output logic                     finished,
  output logic                     failed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    CLAMP = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WORD_SIZE-1:0]     t_q, t_end_q, h_q, h_next_q, n_q, cnt_q;
  logic [ADDRESS_WIDTH-1:0] x0_q, x1_q, cnt_addr;
  logic                     finished_q, failed_q, rejected_q, sat_q;

  logic                     start_ok;
  logic signed [WORD_SIZE:0] sum_ext, rem_ext, h_next_ext;
  logic                     ovf;
  logic [WORD_SIZE-1:0]     t_sat, clamp_h;
  logic                     rem_le0, rem_lt_h, clamp_done;

  generate
    if (ADDRESS_WIDTH > WORD_SIZE) begin : g_cnt_ext
      assign cnt_addr = {{(ADDRESS_WIDTH-WORD_SIZE){1'b0}}, cnt_q};
    end else begin : g_cnt_trunc
      assign cnt_addr = cnt_q[ADDRESS_WIDTH-1:0];
    end
  endgenerate

  assign start_ok = start && !init && (state == IDLE) && !finished_q && !failed_q;

  // Time advance saturates instead of wrapping; an overflow also ends the run.
  assign sum_ext = $signed({t_q[WORD_SIZE-1], t_q}) + $signed({h_q[WORD_SIZE-1], h_q});
  assign ovf     = sum_ext[WORD_SIZE] ^ sum_ext[WORD_SIZE-1];
  assign t_sat   = !ovf               ? sum_ext[WORD_SIZE-1:0] :
                   sum_ext[WORD_SIZE] ? {1'b1, {(WORD_SIZE-1){1'b0}}} :
                                        {1'b0, {(WORD_SIZE-1){1'b1}}};

  // Remaining time is formed one bit wider so t_end - t cannot wrap its sign.
  assign rem_ext    = $signed({t_end_q[WORD_SIZE-1], t_end_q}) - $signed({t_q[WORD_SIZE-1], t_q});
  assign h_next_ext = $signed({h_next_q[WORD_SIZE-1], h_next_q});
  assign rem_le0    = rem_ext[WORD_SIZE] || (rem_ext == '0);
  assign rem_lt_h   = rem_ext < h_next_ext;
  assign clamp_done = sat_q || rem_le0;
  assign clamp_h    = rem_lt_h ? rem_ext[WORD_SIZE-1:0] : h_next_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    accepted    = 1'b0;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (error_failure)  state_nx = HALT;
          else if (proceed)   state_nx = (n_q != '0) ? COPY : CLAMP;
        end
      end
      COPY: begin
        busy = 1'b1;
        if (cnt_q != n_q) mem_rd_addr = x1_q + cnt_addr;
        // Write lags read by one cycle to absorb the memory read latency.
        if (cnt_q != '0) begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = x0_q + cnt_addr - ADDRESS_WIDTH'(1);
          mem_wr_data = mem_rd_data;
        end
        if (cnt_q == n_q) state_nx = CLAMP;
      end
      CLAMP: begin
        busy     = 1'b1;
        accepted = 1'b1;
        state_nx = clamp_done ? HALT : IDLE;
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
    if (init) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q        <= '0;
      t_end_q    <= '0;
      h_q        <= '0;
      h_next_q   <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      finished_q <= 1'b0;
      failed_q   <= 1'b0;
      rejected_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      rejected_q <= 1'b0;
      if (init) begin
        t_q        <= t0_in;
        t_end_q    <= t_end_in;
        h_q        <= h0_in;
        n_q        <= n_in;
        x0_q       <= x0_address;
        x1_q       <= x1_address;
        cnt_q      <= '0;
        finished_q <= 1'b0;
        failed_q   <= 1'b0;
        sat_q      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              if (error_failure) begin
                failed_q <= 1'b1;
              end else if (!proceed) begin
                h_q        <= step_in;
                rejected_q <= 1'b1;
              end else begin
                t_q      <= t_sat;
                sat_q    <= ovf;
                h_next_q <= step_in;
                cnt_q    <= '0;
              end
            end
          end
          COPY: cnt_q <= cnt_q + WORD_SIZE'(1);
          CLAMP: begin
            if (clamp_done) begin
              finished_q <= 1'b1;
              h_q        <= h_next_q;
            end else begin
              h_q <= clamp_h;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign t_out    = t_q;
  assign h_out    = h_q;
  assign rejected = rejected_q;
  assign finished = finished_q;
  assign failed   = failed_q;

endmodule

// File: tb/tb_step_commit_unit.sv
// Directed bench for step_commit_unit: a behavioural memory returns addr ^ 0xA5C3
// as read data and records every write so copied vectors can be checked.
module tb_step_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic [15:0] t0_in = '0, t_end_in = '0, h0_in = '0, n_in = '0;
  logic [15:0] x0_address = '0, x1_address = '0;
  logic        start = 1'b0, proceed = 1'b0, error_failure = 1'b0;
  logic [15:0] step_in = '0;
  logic [15:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [15:0] mem_rd_data = '0;
  logic        mem_wr_en;
  logic [15:0] t_out, h_out;
  logic        busy, accepted, rejected, finished, failed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wmem [0:65535];

  step_commit_unit #(.WORD_SIZE(16), .ADDRESS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .init(init),
    .t0_in(t0_in), .t_end_in(t_end_in), .h0_in(h0_in), .n_in(n_in),
    .x0_address(x0_address), .x1_address(x1_address),
    .start(start), .proceed(proceed), .error_failure(error_failure), .step_in(step_in),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .t_out(t_out), .h_out(h_out), .busy(busy), .accepted(accepted),
    .rejected(rejected), .finished(finished), .failed(failed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= mem_rd_addr ^ 16'hA5C3;
    if (mem_wr_en) wmem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [15:0] t0, input logic [15:0] te, input logic [15:0] h0,
                         input logic [15:0] n, input logic [15:0] x0, input logic [15:0] x1);
    init = 1'b1; t0_in = t0; t_end_in = te; h0_in = h0; n_in = n;
    x0_address = x0; x1_address = x1;
    tick();
    init = 1'b0;
  endtask

  task automatic pulse_start(input logic p, input logic ef, input logic [15:0] st);
    start = 1'b1; proceed = p; error_failure = ef; step_in = st;
    tick();
    start = 1'b0; proceed = 1'b0; error_failure = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (t_out !== 16'h0 || h_out !== 16'h0) begin n_fail++; $display("FAIL reset_th: t=%h h=%h expected 0000 0000", t_out, h_out); end
    n_checks++; if ({busy, accepted, rejected, finished, failed, mem_wr_en} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {busy, accepted, rejected, finished, failed, mem_wr_en}); end
    n_checks++; if (mem_rd_addr !== 16'h0 || mem_wr_addr !== 16'h0 || mem_wr_data !== 16'h0) begin n_fail++; $display("FAIL reset_mem: rd=%h wa=%h wd=%h expected 0", mem_rd_addr, mem_wr_addr, mem_wr_data); end
  endtask

  task automatic test_accept_copy();
    int acc_cnt = 0, acc_cyc = 0, wr_cnt = 0;
    logic busy_bad = 1'b0;
    do_init(16'h0000, 16'h0100, 16'h0020, 16'd3, 16'h0010, 16'h0040);
    pulse_start(1'b1, 1'b0, 16'h0030);
    n_checks++; if (t_out !== 16'h0020) begin n_fail++; $display("FAIL acc_t_early: got %h expected 0020", t_out); end
    for (int j = 1; j <= 8; j++) begin
      if (accepted) begin acc_cnt++; if (acc_cyc == 0) acc_cyc = j; end
      if (j <= 4 && busy !== 1'b1) busy_bad = 1'b1;
      if (j >= 6 && busy !== 1'b0) busy_bad = 1'b1;
      if (j <= 3) begin
        n_checks++; if (mem_rd_addr !== 16'h0040 + 16'(j-1)) begin n_fail++; $display("FAIL acc_rd_addr: cycle %0d got %h expected %h", j, mem_rd_addr, 16'h0040 + 16'(j-1)); end
      end
      if (mem_wr_en) begin
        wr_cnt++;
        n_checks++;
        if (mem_wr_addr !== 16'h0010 + 16'(j-2) || mem_wr_data !== ((16'h0040 + 16'(j-2)) ^ 16'hA5C3)) begin
          n_fail++; $display("FAIL acc_write: cycle %0d got %h<=%h expected %h<=%h", j, mem_wr_addr, mem_wr_data, 16'h0010 + 16'(j-2), (16'h0040 + 16'(j-2)) ^ 16'hA5C3);
        end
      end
      tick();
    end
    n_checks++; if (acc_cyc != 5 || acc_cnt != 1) begin n_fail++; $display("FAIL acc_pulse: cycle %0d count %0d expected cycle 5 count 1", acc_cyc, acc_cnt); end
    n_checks++; if (wr_cnt != 3) begin n_fail++; $display("FAIL acc_wr_count: got %0d expected 3", wr_cnt); end
    n_checks++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL acc_busy: busy profile wrong"); end
    n_checks++; if (h_out !== 16'h0030 || t_out !== 16'h0020) begin n_fail++; $display("FAIL acc_th: t=%h h=%h expected 0020 0030", t_out, h_out); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (wmem[16'h0010 + 16'(k)] !== ((16'h0040 + 16'(k)) ^ 16'hA5C3)) begin n_fail++; $display("FAIL acc_mem: word %0d got %h expected %h", k, wmem[16'h0010 + 16'(k)], (16'h0040 + 16'(k)) ^ 16'hA5C3); end
    end
  endtask

  task automatic test_reject();
    int rej_cnt = 0, wr_cnt = 0;
    do_init(16'h0000, 16'h0100, 16'h0020, 16'd3, 16'h0010, 16'h0040);
    pulse_start(1'b0, 1'b0, 16'h0010);
    n_checks++; if (h_out !== 16'h0010 || t_out !== 16'h0000) begin n_fail++; $display("FAIL rej_th: t=%h h=%h expected 0000 0010", t_out, h_out); end
    for (int j = 1; j <= 4; j++) begin
      if (rejected) rej_cnt++;
      if (mem_wr_en) wr_cnt++;
      tick();
    end
    n_checks++; if (rej_cnt != 1 || wr_cnt != 0) begin n_fail++; $display("FAIL rej_pulse: rejected %0d writes %0d expected 1 0", rej_cnt, wr_cnt); end
  endtask

  task automatic test_clamp_finish();
    int acc_cnt = 0;
    do_init(16'h00E0, 16'h0100, 16'h0010, 16'd0, 16'h0010, 16'h0040);
    pulse_start(1'b1, 1'b0, 16'h0040);
    n_checks++; if (t_out !== 16'h00F0 || accepted !== 1'b1) begin n_fail++; $display("FAIL clamp_t1: t=%h acc=%b expected 00f0 1", t_out, accepted); end
    tick();
    n_checks++; if (h_out !== 16'h0010 || finished !== 1'b0) begin n_fail++; $display("FAIL clamp_h1: h=%h fin=%b expected 0010 0", h_out, finished); end
    pulse_start(1'b1, 1'b0, 16'h0040);
    n_checks++; if (t_out !== 16'h0100) begin n_fail++; $display("FAIL clamp_t2: got %h expected 0100", t_out); end
    tick();
    n_checks++; if (finished !== 1'b1 || h_out !== 16'h0040) begin n_fail++; $display("FAIL clamp_fin: fin=%b h=%h expected 1 0040", finished, h_out); end
    pulse_start(1'b1, 1'b0, 16'h0040);
    for (int j = 1; j <= 3; j++) begin
      if (accepted || rejected) acc_cnt++;
      tick();
    end
    n_checks++; if (acc_cnt != 0 || t_out !== 16'h0100) begin n_fail++; $display("FAIL clamp_ignore: pulses %0d t=%h expected 0 0100", acc_cnt, t_out); end
  endtask

  task automatic test_failure();
    int ev_cnt = 0;
    do_init(16'h0050, 16'h0100, 16'h0020, 16'd2, 16'h0600, 16'h0700);
    pulse_start(1'b1, 1'b1, 16'h0077);
    n_checks++; if (failed !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL fail_flag: failed=%b busy=%b expected 1 0", failed, busy); end
    n_checks++; if (t_out !== 16'h0050 || h_out !== 16'h0020) begin n_fail++; $display("FAIL fail_th: t=%h h=%h expected 0050 0020", t_out, h_out); end
    pulse_start(1'b1, 1'b0, 16'h0030);
    for (int j = 1; j <= 4; j++) begin
      if (accepted || rejected || mem_wr_en || busy) ev_cnt++;
      tick();
    end
    n_checks++; if (ev_cnt != 0 || t_out !== 16'h0050) begin n_fail++; $display("FAIL fail_ignore: events %0d t=%h expected 0 0050", ev_cnt, t_out); end
    do_init(16'h0050, 16'h0100, 16'h0020, 16'd2, 16'h0600, 16'h0700);
    n_checks++; if (failed !== 1'b0) begin n_fail++; $display("FAIL fail_clear: got %b expected 0", failed); end
    pulse_start(1'b0, 1'b0, 16'h0011);
    n_checks++; if (rejected !== 1'b1 || h_out !== 16'h0011) begin n_fail++; $display("FAIL fail_alive: rej=%b h=%h expected 1 0011", rejected, h_out); end
  endtask

  task automatic test_back_to_back();
    int acc_cnt = 0, rej_cnt = 0;
    do_init(16'h0000, 16'h0100, 16'h0020, 16'd3, 16'h0400, 16'h0500);
    pulse_start(1'b1, 1'b0, 16'h0030);
    for (int j = 1; j <= 10; j++) begin
      if (accepted) acc_cnt++;
      if (rejected) rej_cnt++;
      if (j == 1) begin start = 1'b1; proceed = 1'b0; step_in = 16'h0005; end
      if (j == 4) begin start = 1'b0; proceed = 1'b0; step_in = 16'h0000; end
      tick();
    end
    n_checks++; if (acc_cnt != 1 || rej_cnt != 0) begin n_fail++; $display("FAIL b2b_pulses: acc %0d rej %0d expected 1 0", acc_cnt, rej_cnt); end
    n_checks++; if (t_out !== 16'h0020 || h_out !== 16'h0030) begin n_fail++; $display("FAIL b2b_th: t=%h h=%h expected 0020 0030", t_out, h_out); end
  endtask

  task automatic test_saturation();
    do_init(16'h7FF0, 16'h7FFF, 16'h0020, 16'd0, 16'h0010, 16'h0040);
    pulse_start(1'b1, 1'b0, 16'h0010);
    n_checks++; if (t_out !== 16'h7FFF || accepted !== 1'b1) begin n_fail++; $display("FAIL sat_t: t=%h acc=%b expected 7fff 1", t_out, accepted); end
    tick();
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL sat_fin: got %b expected 1", finished); end
  endtask

  task automatic test_reset_mid_copy();
    int wr_cnt = 0;
    do_init(16'h0000, 16'h0100, 16'h0020, 16'd8, 16'h0200, 16'h0300);
    pulse_start(1'b1, 1'b0, 16'h0030);
    if (mem_wr_en) wr_cnt++;
    tick();
    if (mem_wr_en) wr_cnt++;
    tick();
    if (mem_wr_en) wr_cnt++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmc_wr_en: got %b expected 0", mem_wr_en); end
    n_checks++; if ({busy, accepted, rejected, finished, failed} !== 5'b0 || t_out !== 16'h0 || h_out !== 16'h0 || mem_wr_addr !== 16'h0 || mem_rd_addr !== 16'h0) begin
      n_fail++; $display("FAIL rmc_outputs: flags=%b t=%h h=%h wa=%h ra=%h expected all 0", {busy, accepted, rejected, finished, failed}, t_out, h_out, mem_wr_addr, mem_rd_addr);
    end
    #3 rst = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      if (mem_wr_en) wr_cnt++;
      tick();
    end
    n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL rmc_wr_count: got %0d expected 2", wr_cnt); end
    n_checks++; if (wmem[16'h0200] !== (16'h0300 ^ 16'hA5C3)) begin n_fail++; $display("FAIL rmc_mem: got %h expected %h", wmem[16'h0200], 16'h0300 ^ 16'hA5C3); end
  endtask

  initial begin
    #12;
    test_reset();
    #2 rst = 1'b1;
    tick();
    test_accept_copy();
    test_reject();
    test_clamp_finish();
    test_failure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
